// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - two-read/one-write register bank with negedge sequential clear FSM
// Optional macro REG_BANK_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_bank #(
  parameter int N        = 24,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr1,
  output logic [N-1:0]  rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [N-1:0]  rdata2,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t        state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  mem_q [DEPTH];

  logic          zero_addr;
  logic          wr_ok;

  // Address 0 is only special when the zero register is enabled.
  assign zero_addr = (ZERO_REG != 0) && (waddr == '0);
  assign wr_ok     = we && (state_q == IDLE) && !zero_addr;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_ok) begin
            mem_q[waddr] <= wdata;
          end
          if (clr_req) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          mem_q[cnt_q] <= '0;
          // Stop at the last entry rather than letting the counter wrap.
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [N-1:0] read_port(input logic [AW-1:0] a);
    logic [N-1:0] v;
    v = mem_q[a];
`ifdef REG_BANK_BYPASS_EN
    if (we && (state_q == IDLE) && (a == waddr) && !zero_addr) begin
      v = wdata;
    end
`endif
    if ((ZERO_REG != 0) && (a == '0)) begin
      v = '0;
    end
    if (!rst) begin
      v = '0;
    end
    return v;
  endfunction

  always_comb begin
    rdata1 = read_port(raddr1);
  end

  always_comb begin
    rdata2 = read_port(raddr2);
  end

  assign clr_busy = busy_q;
  assign clr_done = done_q;

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - randomized scoreboard bench for reg_bank against a clear-timeline model
module tb_reg_bank;
  localparam int N     = 24;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic          clr_req = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] raddr1 = '0;
  logic [AW-1:0] raddr2 = '0;
  logic [N-1:0]  wdata = '0;
  logic [N-1:0]  rdata1;
  logic [N-1:0]  rdata2;
  logic          clr_busy;
  logic          clr_done;

  always #5 clk = ~clk;

  reg_bank #(.N(N), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  typedef struct {
    logic [N-1:0] r1;
    logic [N-1:0] r2;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int obs_busy = 0;
  int obs_done = 0;

  // Model: t counts negedges since a clear began (0 = idle, 1..DEPTH = clearing
  // entry t-1, DEPTH+1 = done cycle).
  logic [N-1:0] m [DEPTH];
  int t = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [N-1:0] model_read(input logic [AW-1:0] a);
    if (!rst || a == 0) return '0;
`ifdef REG_BANK_BYPASS_EN
    if (we && t == 0 && a == waddr) return wdata;
`endif
    return m[a];
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rdata1", rdata1, e.r1);
      check("rdata2", rdata2, e.r2);
      check("clr_busy", N'(clr_busy), N'(e.busy));
      check("clr_done", N'(clr_done), N'(e.done));
    end
  end

  task automatic cycle(input logic we_, input logic [AW-1:0] wa, input logic [N-1:0] wd,
                       input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                       input logic clr, input logic rst_);
    exp_t e;
    @(posedge clk);
    rst = rst_; we = we_; waddr = wa; wdata = wd;
    raddr1 = ra1; raddr2 = ra2; clr_req = clr;
    e.r1   = model_read(ra1);
    e.r2   = model_read(ra2);
    e.busy = rst && (t >= 1);
    e.done = rst && (t == DEPTH + 1);
    exp_q.push_back(e);
    #3;
    obs_busy += int'(clr_busy);
    obs_done += int'(clr_done);
    @(negedge clk);
    #1;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
      t = 0;
    end else if (t == 0) begin
      if (we && waddr != 0) m[waddr] = wdata;
      if (clr_req) t = 1;
    end else if (t <= DEPTH) begin
      m[t-1] = '0;
      t++;
    end else begin
      t = 0;
    end
  endtask

  task automatic rand_cycle(input logic clr, input logic rst_);
    cycle(1'($urandom), AW'($urandom), N'($urandom), AW'($urandom), AW'($urandom), clr, rst_);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m[i] = '0;

    cycle(1'b1, 4'd7, 24'h777777, 4'd7, 4'd7, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, '0, 4'd7, 4'd1, 1'b0, 1'b0);

    cycle(1'b1, 4'd5, 24'hABCDEF, 4'd5, 4'd4, 1'b0, 1'b1);
    cycle(1'b0, 4'd0, '0, 4'd5, 4'd4, 1'b0, 1'b1);
    check("write_addr5", rdata1, 24'hABCDEF);
    check("unwritten_addr4", rdata2, '0);

    cycle(1'b1, 4'd0, 24'h123456, 4'd0, 4'd5, 1'b0, 1'b1);
    check("zero_reg", rdata1, '0);

    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, AW'(i), 24'hFFFFFF, AW'(i), AW'(i + 15), 1'b0, 1'b1);
    cycle(1'b0, 4'd0, '0, 4'd9, 4'd3, 1'b0, 1'b1);
    check("filled_9", rdata1, 24'hFFFFFF);

    obs_busy = 0;
    obs_done = 0;
    cycle(1'b0, 4'd0, '0, 4'd3, 4'd15, 1'b1, 1'b1);
    for (int k = 0; k < DEPTH + 1; k++)
      cycle(1'b1, 4'd3, 24'h000055, AW'($urandom), AW'($urandom), 1'b0, 1'b1);
    cycle(1'b0, 4'd0, '0, 4'd3, 4'd15, 1'b0, 1'b1);
    check("busy_cycles", N'(obs_busy), N'(DEPTH + 1));
    check("done_pulses", N'(obs_done), N'(1));
    check("entry3_after_clear", rdata1, '0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 4'd0, '0, AW'(i), AW'(15 - i), 1'b0, 1'b1);
      check("cleared_entry", rdata1, '0);
    end

    for (int i = 1; i < DEPTH; i++)
      cycle(1'b1, AW'(i), N'($urandom), 4'd0, 4'd0, 1'b0, 1'b1);
    obs_done = 0;
    cycle(1'b0, 4'd0, '0, 4'd12, 4'd2, 1'b1, 1'b1);
    for (int k = 0; k < 20 && t != 8; k++)
      cycle(1'b0, 4'd0, '0, 4'd12, 4'd2, 1'b0, 1'b1);
    check("reached_cnt7", N'(t), N'(8));
    cycle(1'b1, 4'd12, 24'h0000AA, 4'd12, 4'd9, 1'b0, 1'b0);
    check("busy_in_reset", N'(clr_busy), '0);
    check("rdata_in_reset", rdata1, '0);
    cycle(1'b0, 4'd0, '0, 4'd12, 4'd14, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++)
      cycle(1'b0, 4'd0, '0, AW'(k), AW'(k + 1), 1'b0, 1'b1);
    check("no_done_after_abort", N'(obs_done), '0);
    check("idle_after_abort", N'(clr_busy), '0);

    cycle(1'b1, 4'd9, 24'h111111, 4'd0, 4'd0, 1'b0, 1'b1);
    cycle(1'b1, 4'd9, 24'h00BEEF, 4'd1, 4'd9, 1'b0, 1'b1);
    check("bypass_after_edge", rdata2, 24'h00BEEF);

    for (int k = 0; k < 45; k++) rand_cycle(1'b1, 1'b1);
    for (int k = 0; k < 400; k++)
      rand_cycle(($urandom % 20) == 0, ($urandom % 60) != 0);

    cycle(1'b0, 4'd0, '0, 4'd0, 4'd0, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("scoreboard_drained", N'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter N, default 24, data width of every entry in bits.
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, at least 2.
REQ-003 Parameter ZERO_REG, default 1; when 1, entry 0 always reads 0 and ignores writes.
REQ-004 Localparam AW SHALL equal $clog2(DEPTH).
REQ-005 clk  in  1  single clock; all state updates on the negedge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 we  in  1  write enable for the write port.
REQ-008 waddr  in  AW  write address.
REQ-009 wdata  in  N  write data.
REQ-010 raddr1  in  AW  read address, port 1.
REQ-011 rdata1  out  N  read data, port 1, combinational.
REQ-012 raddr2  in  AW  read address, port 2.
REQ-013 rdata2  out  N  read data, port 2, combinational.
REQ-014 clr_req  in  1  request a sequential clear of all entries.
REQ-015 clr_busy  out  1  clear sequence in progress.
REQ-016 clr_done  out  1  one-cycle pulse when the clear completes.

Function
REQ-017 A write SHALL update entry waddr with wdata on the negedge of clk when we=1 and the FSM is in IDLE.
REQ-018 Read ports SHALL be asynchronous: rdataX = entry[raddrX]; both ports SHALL be independent, and the same address on both ports SHALL be legal.
REQ-019 When ZERO_REG=1, rdataX SHALL be 0 for raddrX=0 and writes to address 0 SHALL be discarded.
REQ-020 Clear FSM states SHALL be IDLE, CLEAR and DONE; the FSM SHALL sample its inputs on the negedge.
REQ-021 IDLE->CLEAR SHALL occur when clr_req=1; the clear counter SHALL load 0.
REQ-022 In CLEAR, each negedge SHALL write 0 to entry[cnt] and increment cnt; at cnt=DEPTH-1 that entry SHALL be cleared and the FSM SHALL enter DONE.
REQ-023 The clear SHALL take exactly DEPTH negedges in CLEAR.
REQ-024 DONE SHALL last one cycle, with clr_done=1, and SHALL then return to IDLE.
REQ-025 clr_busy SHALL be 1 in CLEAR and DONE and 0 in IDLE.
REQ-026 In CLEAR and DONE, external writes (we=1) SHALL be dropped silently.
REQ-027 clr_req in CLEAR or DONE SHALL be ignored; a clr_req held high across DONE SHALL start a new clear from IDLE.
REQ-028 On a simultaneous we=1 and clr_req=1 in IDLE, the write SHALL be performed and the FSM SHALL enter CLEAR on the same edge.
REQ-029 The counter SHALL be AW bits wide and SHALL never wrap inside a sequence.

Reset
REQ-030 rst=0 SHALL immediately, independent of clk, clear every entry to 0, force the FSM to IDLE, and set cnt=0.
REQ-031 While rst=0, clr_busy=0, clr_done=0, and rdata1/rdata2 SHALL be 0.
REQ-032 rst asserted mid-clear SHALL abort the sequence; after release the FSM SHALL be in IDLE with no clr_done pulse.
REQ-033 Writes SHALL resume on the first negedge after rst returns to 1.

Configuration
REQ-034 Macro REG_BANK_BYPASS_EN, when defined, SHALL make rdataX return wdata combinationally when we=1, raddrX=waddr, the FSM is in IDLE, and the address is not a discarded zero-register address.
REQ-035 Without REG_BANK_BYPASS_EN, rdataX SHALL always reflect the stored entry; a same-cycle write becomes visible only after the negedge.

Verification
REQ-036 Reset then write: rst=0, then release; write 24'hABCDEF to address 5; read raddr1=5 after the negedge -> rdata1=24'hABCDEF, rdata2 (raddr2=4)=0.
REQ-037 Zero register: ZERO_REG=1; write 24'h123456 to address 0 -> rdata1=0 at raddr1=0.
REQ-038 Clear sequence: fill all 16 entries with 24'hFFFFFF; pulse clr_req -> clr_busy=1 for 17 cycles, clr_done pulses once after the 16th clear negedge, all entries read 0.
REQ-039 Write during clear: we=1, waddr=3, wdata=24'h000055 while clr_busy=1 -> entry 3 reads 0 after clr_done.
REQ-040 Reset mid-clear: assert rst at cnt=7 -> clr_busy=0 immediately, all entries 0, no clr_done pulse, FSM in IDLE after release.
REQ-041 Bypass: with REG_BANK_BYPASS_EN defined, we=1, waddr=raddr2=9, wdata=24'h00BEEF before the negedge -> rdata2=24'h00BEEF; without the macro, rdata2 shows the old value until the negedge.
